// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO ingress arbiter and its picker.
//   arb_state_t : arbiter FSM encoding (IDLE / XFER)
//   lb_min1()   : index width for N requesters, never less than 1 bit
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_t;

  function automatic int unsigned lb_min1(input int unsigned n);
    return (n < 3) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/fifo_ingress_arbiter_if.sv
// Handshake bundle between NUM_REQ packet requesters, the ingress arbiter
// and the FIFO write port.
//   req_data/req_valid/req_last : requester beats (requesters -> arbiter)
//   req_ready                   : per-requester accept (arbiter -> requesters)
//   fifo_data/fifo_valid        : slice output to FIFO in_data/in_valid
//   fifo_ready                  : FIFO in_ready
// modport slave  : the arbiter's view
// modport master : the surrounding environment (requesters + FIFO)
interface fifo_ingress_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4
);
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_last;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [DATA_WIDTH-1:0]              fifo_data;
  logic                               fifo_valid;
  logic                               fifo_ready;

  modport slave (
    input  req_data, req_valid, req_last, fifo_ready,
    output req_ready, fifo_data, fifo_valid
  );

  modport master (
    output req_data, req_valid, req_last, fifo_ready,
    input  req_ready, fifo_data, fifo_valid
  );
endinterface

// File: rtl/fifo_ingress_arbiter_rr_pick.sv
// Combinational rotating-priority picker.
//   req    : request vector
//   rr_ptr : index with highest priority this cycle
//   found  : at least one request is set
//   idx    : first set request at or above rr_ptr, wrapping modulo NUM_REQ
import fifo_arb_pkg::*;

module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = lb_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic               found,
  output logic [PTR_W-1:0]   idx
);

  int unsigned cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // rr_ptr < NUM_REQ, so a single subtraction completes the wrap
      cand = 32'(rr_ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[cand[PTR_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_ingress_arbiter.sv
// Round-robin, packet-locked arbiter sharing one FIFO write port among
// NUM_REQ requesters, with a registered single-beat output slice.
//   clk, rstn   : clock, asynchronous active-low reset
//   clear       : synchronous flush (shared with the FIFO clear)
//   bus         : requester and FIFO handshakes (slave modport)
//   fifo_count  : FIFO fill level
//   grant_id    : current or most recent packet owner
//   busy        : a packet owns the port
//   throttled   : registered fifo_count >= HIGH_WATER; blocks new grants only
import fifo_arb_pkg::*;

module fifo_ingress_arbiter #(
  parameter  int unsigned DATA_WIDTH    = 8,
  parameter  int unsigned FIFO_DEPTH    = 256,
  parameter  int unsigned NUM_REQ       = 4,
  parameter  int unsigned HIGH_WATER    = FIFO_DEPTH - 16,
  localparam int unsigned LB_FIFO_DEPTH = $clog2(FIFO_DEPTH),
  localparam int unsigned LB_NUM_REQ    = lb_min1(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clear,
  fifo_ingress_arbiter_if.slave    bus,
  input  logic [LB_FIFO_DEPTH:0]   fifo_count,
  output logic [LB_NUM_REQ-1:0]    grant_id,
  output logic                     busy,
  output logic                     throttled
);

  localparam logic [LB_FIFO_DEPTH:0] HW_CNT  = (LB_FIFO_DEPTH + 1)'(HIGH_WATER);
  localparam logic [LB_NUM_REQ-1:0]  LAST_ID = LB_NUM_REQ'(NUM_REQ - 1);

  arb_state_t            state_q, state_d;
  logic [LB_NUM_REQ-1:0] rr_ptr_q;
  logic [LB_NUM_REQ-1:0] pick_idx;
  logic                  pick_found;
  logic                  throttled_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  slot_free;
  logic                  start_grant;
  logic                  accept;
  logic                  accept_last;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (LB_NUM_REQ)
  ) u_pick (
    .req    (bus.req_valid),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  // State register; clear overrides any transition
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      state_q <= ARB_IDLE;
    else if (clear) state_q <= ARB_IDLE;
    else            state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (start_grant) state_d = ARB_XFER;
      ARB_XFER: if (accept_last) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // Outputs and handshake qualifiers
  always_comb begin
    busy          = (state_q == ARB_XFER);
    slot_free     = !valid_q || bus.fifo_ready;
    // throttle only gates new packets; an owned packet always runs to its end
    start_grant   = (state_q == ARB_IDLE) && pick_found && !throttled_q;
    bus.req_ready = '0;
    if (state_q == ARB_XFER) bus.req_ready[grant_id] = slot_free;
    accept        = (state_q == ARB_XFER) && bus.req_valid[grant_id] && slot_free;
    accept_last   = accept && bus.req_last[grant_id];
  end

  // Grant, round-robin pointer, output slice and throttle register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q     <= 1'b0;
      data_q      <= '0;
      grant_id    <= '0;
      rr_ptr_q    <= '0;
      throttled_q <= 1'b0;
    end else begin
      throttled_q <= (fifo_count >= HW_CNT);
      if (clear) begin
        // slice contents are dropped together with the FIFO; grant_id is kept
        valid_q  <= 1'b0;
        rr_ptr_q <= '0;
      end else begin
        if (start_grant) grant_id <= pick_idx;
        if (accept) begin
          data_q  <= bus.req_data[grant_id];
          valid_q <= 1'b1;
        end else if (bus.fifo_ready) begin
          valid_q <= 1'b0;
        end
        if (accept_last) rr_ptr_q <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
      end
    end
  end

  assign bus.fifo_valid = valid_q;
  assign bus.fifo_data  = data_q;
  assign throttled      = throttled_q;

endmodule

// File: tb/tb_fifo_ingress_arbiter.sv
// Testbench for fifo_ingress_arbiter: directed vector table plus hand-written
// multi-cycle sequences (throttle, round-robin, clear and reset mid-packet).
module tb_fifo_ingress_arbiter;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned HW    = 240;

  logic       clk = 1'b0;
  logic       rstn;
  logic       clear;
  logic [8:0] fifo_count;
  logic [1:0] grant_id;
  logic       busy;
  logic       throttled;

  fifo_ingress_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NREQ)) bus ();

  fifo_ingress_arbiter #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .NUM_REQ    (NREQ),
    .HIGH_WATER (HW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (clear),
    .bus        (bus),
    .fifo_count (fifo_count),
    .grant_id   (grant_id),
    .busy       (busy),
    .throttled  (throttled)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        fr;
    logic [8:0]  cnt;
    logic        clr;
    logic [3:0]  e_rdy;
    logic        e_busy;
    logic [1:0]  e_gid;
    logic        e_fv;
    logic [7:0]  e_fd;
    logic        e_thr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                              input logic fr, input logic [8:0] cnt,
                              input logic [3:0] e_rdy, input logic e_busy, input logic [1:0] e_gid,
                              input logic e_fv, input logic [7:0] e_fd, input logic e_thr,
                              input logic clr = 1'b0);
    vec_t t;
    t.v = v; t.l = l; t.d = d; t.fr = fr; t.cnt = cnt; t.clr = clr;
    t.e_rdy = e_rdy; t.e_busy = e_busy; t.e_gid = e_gid;
    t.e_fv = e_fv; t.e_fd = e_fd; t.e_thr = e_thr;
    return t;
  endfunction

  // Drive a vector just after the rising edge, check outputs at the falling edge
  task automatic run_vec(input vec_t t, input string tag);
    @(posedge clk);
    #1;
    bus.req_valid  = t.v;
    bus.req_last   = t.l;
    bus.req_data   = t.d;
    bus.fifo_ready = t.fr;
    fifo_count     = t.cnt;
    clear          = t.clr;
    @(negedge clk);
    chk({tag, " req_ready"},  32'(bus.req_ready),  32'(t.e_rdy));
    chk({tag, " busy"},       32'(busy),           32'(t.e_busy));
    chk({tag, " grant_id"},   32'(grant_id),       32'(t.e_gid));
    chk({tag, " fifo_valid"}, 32'(bus.fifo_valid), 32'(t.e_fv));
    chk({tag, " fifo_data"},  32'(bus.fifo_data),  32'(t.e_fd));
    chk({tag, " throttled"},  32'(throttled),      32'(t.e_thr));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " fifo_valid"}, 32'(bus.fifo_valid), 32'd0);
    chk({tag, " fifo_data"},  32'(bus.fifo_data),  32'd0);
    chk({tag, " grant_id"},   32'(grant_id),       32'd0);
    chk({tag, " busy"},       32'(busy),           32'd0);
    chk({tag, " throttled"},  32'(throttled),      32'd0);
    chk({tag, " req_ready"},  32'(bus.req_ready),  32'd0);
  endtask

  // round-robin stream bookkeeping
  int unsigned beat_n[4];
  int unsigned pkt_n[4];
  logic [3:0]  fire;
  logic        prev_busy;
  logic        stop;
  logic [7:0]  beats_q[$];
  logic [1:0]  grants_q[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn           = 1'b0;
    clear          = 1'b0;
    bus.req_valid  = '0;
    bus.req_last   = '0;
    bus.req_data   = '0;
    bus.fifo_ready = 1'b1;
    fifo_count     = '0;

    // single requester (ch2, 3 beats), then ch3 from rr_ptr=3, then ch0 with backpressure
    tbl.push_back(mk(4'b0100, 4'b0000, 32'h00A1_0000, 1, 0,   4'b0000, 0, 2'd0, 0, 8'h00, 0));
    tbl.push_back(mk(4'b0100, 4'b0000, 32'h00A1_0000, 1, 0,   4'b0100, 1, 2'd2, 0, 8'h00, 0));
    tbl.push_back(mk(4'b0100, 4'b0000, 32'h00A2_0000, 1, 0,   4'b0100, 1, 2'd2, 1, 8'hA1, 0));
    tbl.push_back(mk(4'b0100, 4'b0100, 32'h00A3_0000, 1, 0,   4'b0100, 1, 2'd2, 1, 8'hA2, 0));
    tbl.push_back(mk(4'b0000, 4'b0000, 32'h0000_0000, 1, 0,   4'b0000, 0, 2'd2, 1, 8'hA3, 0));
    tbl.push_back(mk(4'b1111, 4'b1111, 32'hB3B2_B1B0, 1, 0,   4'b0000, 0, 2'd2, 0, 8'hA3, 0));
    tbl.push_back(mk(4'b1111, 4'b1111, 32'hB3B2_B1B0, 1, 0,   4'b1000, 1, 2'd3, 0, 8'hA3, 0));
    tbl.push_back(mk(4'b0001, 4'b0000, 32'h0000_00C1, 1, 0,   4'b0000, 0, 2'd3, 1, 8'hB3, 0));
    tbl.push_back(mk(4'b0001, 4'b0000, 32'h0000_00C1, 1, 0,   4'b0001, 1, 2'd0, 0, 8'hB3, 0));
    tbl.push_back(mk(4'b0001, 4'b0000, 32'h0000_00C2, 0, 0,   4'b0000, 1, 2'd0, 1, 8'hC1, 0));
    tbl.push_back(mk(4'b0011, 4'b0010, 32'h0000_EEC2, 0, 0,   4'b0000, 1, 2'd0, 1, 8'hC1, 0));
    tbl.push_back(mk(4'b0001, 4'b0000, 32'h0000_00C2, 0, 0,   4'b0000, 1, 2'd0, 1, 8'hC1, 0));
    tbl.push_back(mk(4'b0001, 4'b0000, 32'h0000_00C2, 0, 0,   4'b0000, 1, 2'd0, 1, 8'hC1, 0));
    tbl.push_back(mk(4'b0001, 4'b0000, 32'h0000_00C2, 0, 0,   4'b0000, 1, 2'd0, 1, 8'hC1, 0));
    tbl.push_back(mk(4'b0001, 4'b0000, 32'h0000_00C2, 1, 0,   4'b0001, 1, 2'd0, 1, 8'hC1, 0));
    tbl.push_back(mk(4'b0001, 4'b0001, 32'h0000_00C3, 1, 0,   4'b0001, 1, 2'd0, 1, 8'hC2, 0));
    tbl.push_back(mk(4'b0000, 4'b0000, 32'h0000_0000, 1, 0,   4'b0000, 0, 2'd0, 1, 8'hC3, 0));
    tbl.push_back(mk(4'b0000, 4'b0000, 32'h0000_0000, 1, 0,   4'b0000, 0, 2'd0, 0, 8'hC3, 0));

    #12;
    chk_reset("por");
    @(negedge clk) rstn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("tbl[%0d]", i));

    // throttle in IDLE: count at HIGH_WATER blocks, dropping to HIGH_WATER-1 grants two cycles later
    run_vec(mk(4'b0000, 4'b0000, 32'h0000_0000, 1, 240, 4'b0000, 0, 2'd0, 0, 8'hC3, 0), "thr0");
    run_vec(mk(4'b0010, 4'b0010, 32'h0000_D100, 1, 240, 4'b0000, 0, 2'd0, 0, 8'hC3, 1), "thr1");
    run_vec(mk(4'b0010, 4'b0010, 32'h0000_D100, 1, 240, 4'b0000, 0, 2'd0, 0, 8'hC3, 1), "thr2");
    run_vec(mk(4'b0010, 4'b0010, 32'h0000_D100, 1, 239, 4'b0000, 0, 2'd0, 0, 8'hC3, 1), "thr3");
    run_vec(mk(4'b0010, 4'b0010, 32'h0000_D100, 1, 239, 4'b0000, 0, 2'd0, 0, 8'hC3, 0), "thr4");
    run_vec(mk(4'b0010, 4'b0010, 32'h0000_D100, 1, 239, 4'b0010, 1, 2'd1, 0, 8'hC3, 0), "thr5");
    run_vec(mk(4'b0000, 4'b0000, 32'h0000_0000, 1, 0,   4'b0000, 0, 2'd1, 1, 8'hD1, 0), "thr6");

    // throttle rising mid-packet: the packet finishes, then no new grant
    run_vec(mk(4'b0100, 4'b0000, 32'h00E1_0000, 1, 0,   4'b0000, 0, 2'd1, 0, 8'hD1, 0), "mid0");
    run_vec(mk(4'b0100, 4'b0000, 32'h00E1_0000, 1, 240, 4'b0100, 1, 2'd2, 0, 8'hD1, 0), "mid1");
    run_vec(mk(4'b0100, 4'b0100, 32'h00E2_0000, 1, 240, 4'b0100, 1, 2'd2, 1, 8'hE1, 1), "mid2");
    run_vec(mk(4'b1111, 4'b1111, 32'hF3F2_F1F0, 1, 240, 4'b0000, 0, 2'd2, 1, 8'hE2, 1), "mid3");
    run_vec(mk(4'b1111, 4'b1111, 32'hF3F2_F1F0, 1, 240, 4'b0000, 0, 2'd2, 0, 8'hE2, 1), "mid4");
    run_vec(mk(4'b0000, 4'b0000, 32'h0000_0000, 1, 0,   4'b0000, 0, 2'd2, 0, 8'hE2, 1), "mid5");
    run_vec(mk(4'b0000, 4'b0000, 32'h0000_0000, 1, 0,   4'b0000, 0, 2'd2, 0, 8'hE2, 0), "mid6");

    // reset while idle puts rr_ptr back to 0
    @(negedge clk) rstn = 1'b0;
    #1 chk_reset("rst_idle");
    @(negedge clk) rstn = 1'b1;

    // round-robin: all four requesters stream 2-beat packets continuously
    for (int c = 0; c < 4; c++) begin
      beat_n[c] = 0;
      pkt_n[c]  = 0;
    end
    fire      = '0;
    prev_busy = 1'b0;
    stop      = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 4; c++) begin
        if (fire[c]) begin
          if (beat_n[c] == 1) begin
            beat_n[c] = 0;
            pkt_n[c]  = pkt_n[c] + 1;
          end else begin
            beat_n[c] = 1;
          end
        end
      end
      if (stop) break;
      bus.req_valid = 4'b1111;
      for (int c = 0; c < 4; c++) begin
        bus.req_data[c] = 8'(c * 64 + (pkt_n[c] % 32) * 2 + beat_n[c]);
        bus.req_last[c] = (beat_n[c] == 1);
      end
      @(negedge clk);
      fire = bus.req_valid & bus.req_ready;
      if (busy && !prev_busy) grants_q.push_back(grant_id);
      prev_busy = busy;
      if (bus.fifo_valid && bus.fifo_ready) beats_q.push_back(bus.fifo_data);
      if (beats_q.size() >= 10 && |(fire & bus.req_last)) stop = 1'b1;
    end
    bus.req_valid = '0;
    bus.req_last  = '0;
    chk("rr stream completed", 32'(stop), 32'd1);
    for (int k = 0; k < 5; k++)
      chk($sformatf("rr grant[%0d]", k),
          (k < grants_q.size()) ? 32'(grants_q[k]) : 32'hDEAD, 32'(k % 4));
    for (int k = 0; k < 10; k++)
      chk($sformatf("rr beat[%0d]", k),
          (k < beats_q.size()) ? 32'(beats_q[k]) : 32'hDEAD,
          32'(((k / 2) % 4) * 64 + ((k / 2) / 4) * 2 + (k % 2)));

    // clear mid-packet: IDLE, slice empty, rr_ptr 0, grant_id held
    bus.req_data = '0;
    @(posedge clk); #1;
    bus.req_valid = 4'b0010; bus.req_last = 4'b0000; bus.req_data = 32'h0000_5500;
    @(negedge clk); chk("clr0 busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("clr1 busy", 32'(busy), 32'd1);
    chk("clr1 grant_id", 32'(grant_id), 32'd1);
    chk("clr1 req_ready", 32'(bus.req_ready), 32'b0010);
    @(posedge clk); #1;
    clear = 1'b1; bus.req_data = 32'h0000_5600;
    @(negedge clk);
    chk("clr2 fifo_valid", 32'(bus.fifo_valid), 32'd1);
    chk("clr2 fifo_data", 32'(bus.fifo_data), 32'h55);
    @(posedge clk); #1;
    clear = 1'b0; bus.req_valid = 4'b1111; bus.req_last = 4'b1111; bus.req_data = '0;
    @(negedge clk);
    chk("clr3 busy", 32'(busy), 32'd0);
    chk("clr3 fifo_valid", 32'(bus.fifo_valid), 32'd0);
    chk("clr3 grant_id held", 32'(grant_id), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("clr4 busy", 32'(busy), 32'd1);
    chk("clr4 grant_id from rr_ptr 0", 32'(grant_id), 32'd0);
    @(posedge clk); #1;
    bus.req_valid = '0; bus.req_last = '0;
    @(negedge clk);
    chk("clr5 busy", 32'(busy), 32'd0);
    chk("clr5 fifo_valid", 32'(bus.fifo_valid), 32'd1);

    // reset mid-packet: all outputs return to reset values at once
    @(posedge clk); #1;
    bus.req_valid = 4'b0100; bus.req_last = 4'b0000; bus.req_data = 32'h0077_0000; fifo_count = 9'd240;
    @(negedge clk); chk("rstp0 busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstp1 busy", 32'(busy), 32'd1);
    chk("rstp1 grant_id", 32'(grant_id), 32'd2);
    chk("rstp1 throttled", 32'(throttled), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstp2 fifo_valid", 32'(bus.fifo_valid), 32'd1);
    chk("rstp2 fifo_data", 32'(bus.fifo_data), 32'h77);
    #2 rstn = 1'b0;
    #1 chk_reset("rst_mid");
    @(posedge clk); #1 chk_reset("rst_hold");
    @(negedge clk);
    rstn = 1'b1; fifo_count = '0; bus.req_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_rel busy", 32'(busy), 32'd0);
    chk("rst_rel throttled", 32'(throttled), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_ingress_arbiter.md
# fifo_ingress_arbiter

- Shares the write port of the interleaved synchronous FIFO among `NUM_REQ` packet-oriented valid-ready requesters.
- Arbitration is round-robin, with the grant locked for a whole packet.
- Output is a registered single-beat slice that drives the FIFO `in_data`/`in_valid`/`in_ready` handshake.
- New grants are withheld while the FIFO `count` is at or above a high-water mark, so one producer cannot fill the FIFO while another is mid-packet.

## Interface

- `DATA_WIDTH`, 8, payload width; equals the FIFO data width.
- `FIFO_DEPTH`, 256, capacity of the downstream FIFO; sets the `fifo_count` width.
- `NUM_REQ`, 4, number of requesters, 2..16.
- `HIGH_WATER`, `FIFO_DEPTH-16`, count at or above which no new packet is granted.
- localparam `LB_FIFO_DEPTH` = `$clog2(FIFO_DEPTH)`; `LB_NUM_REQ` = `$clog2(NUM_REQ)`.
- `clk`  in  1  single clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous flush, tied to the FIFO `clear`.
- `req_data`  in  `NUM_REQ`×`DATA_WIDTH`  per-requester payload.
- `req_valid`  in  `NUM_REQ`  per-requester beat valid.
- `req_last`  in  `NUM_REQ`  final beat of the packet.
- `req_ready`  out  `NUM_REQ`  per-requester beat accept.
- `fifo_data`  out  `DATA_WIDTH`  to FIFO `in_data`.
- `fifo_valid`  out  1  to FIFO `in_valid`.
- `fifo_ready`  in  1  from FIFO `in_ready`.
- `fifo_count`  in  `LB_FIFO_DEPTH+1`  from FIFO `count`.
- `grant_id`  out  `LB_NUM_REQ`  currently or last granted requester.
- `busy`  out  1  state is XFER.
- `throttled`  out  1  registered (`fifo_count >= HIGH_WATER`).

## Operation

- FSM states:
  - **IDLE**: no requester owns the port.
  - **XFER**: requester `grant_id` owns the port.
- **IDLE → XFER**
  - Condition: any `req_valid` is high and `throttled` is 0.
  - The winner is the first valid requester, searching upward from `rr_ptr` with modulo-`NUM_REQ` wrap.
  - The winner is registered into `grant_id`.
- **In XFER**
  - `req_ready[grant_id] = !fifo_valid | fifo_ready`; all other `req_ready` bits are 0.
  - A beat is accepted when `req_valid & req_ready` on the granted channel; it loads `fifo_data` and sets `fifo_valid`.
  - `fifo_valid` clears when `fifo_ready` is high and no new beat is accepted.
- **XFER → IDLE**
  - Condition: an accepted beat has `req_last` high.
  - `rr_ptr` <= `grant_id+1`, wrapping to 0 at `NUM_REQ`.
- Once granted, a packet always completes:
  - Throttle is evaluated only in IDLE.
  - FIFO overflow is prevented solely by `fifo_ready`.
- A granted requester that drops `req_valid` mid-packet stalls the port. No timeout exists.
- `req_last` on a non-granted channel is ignored.
- **clear**
  - State goes to IDLE, `fifo_valid` to 0, `rr_ptr` to 0; `grant_id` is held.
  - Any beat held in the slice is discarded, consistent with the FIFO flush.
  - `clear` has priority over all other events in the same cycle.
- **Reset**
  - Outputs: `fifo_valid` 0, `fifo_data` 0, `grant_id` 0, `busy` 0, `throttled` 0, all `req_ready` 0.
  - Internal: state IDLE, `rr_ptr` 0.
  - A reset mid-packet abandons the packet. The requester must restart it.

## Timing

- **Grant latency:** with `req_valid` high in IDLE at cycle t, the state is XFER and `grant_id` is valid at t+1.
- **First beat:** accepted at t+1 when the slice is empty; `fifo_valid` is high at t+2.
- **Throughput:** one beat per cycle while `fifo_ready` stays high.
- **Packet cost:** an L-beat packet occupies at least L+1 cycles (one IDLE arbitration bubble).
- **`throttled` lag:** it is registered from `fifo_count`, so it trails the count by 1 cycle.
- **HIGH_WATER headroom:** must leave room for that lag plus one slice beat. This affects fairness only, not correctness.
- **Path isolation:** no combinational path from `fifo_ready` to `fifo_valid`. `req_ready` depends combinationally on `fifo_ready`.

## Structure

- Package `fifo_arb_pkg` holds:
  - the `arb_state_t` enum {`ARB_IDLE`, `ARB_XFER`};
  - the function computing `LB_NUM_REQ` with a minimum of 1.
- Sub-module `rr_pick`: combinational rotating-priority picker.
  - Inputs: `NUM_REQ` request vector and `rr_ptr`.
  - Outputs: `found` and winner index.
  - Reusable for the read side.
- The top holds the FSM, `rr_ptr`, the output slice and the throttle register.

## Test plan

- **Single requester:** `NUM_REQ`=4; req 2 sends a 3-beat packet 0xA1,0xA2,0xA3 with `fifo_ready`=1 → `grant_id`=2; `fifo_valid` high for 3 consecutive cycles; `rr_ptr`=3 afterwards.
- **Round-robin:** all 4 requesters send 2-beat packets continuously → grant order 0,1,2,3,0; no interleaving of beats within a packet.
- **Backpressure:** `fifo_ready` held 0 for 5 cycles mid-packet → `fifo_data` stable, `req_ready` 0, no beat lost or duplicated; the stream resumes in order.
- **Throttle:** `fifo_count`=`HIGH_WATER` while in IDLE → no grant and `throttled`=1; count drops to `HIGH_WATER-1` → grant on the second following cycle.
- **Throttle mid-packet:** `fifo_count` rises to `HIGH_WATER` during a packet → the packet completes, then the block idles.
- **Clear and reset mid-packet:** `clear` asserted mid-packet → next cycle IDLE, `fifo_valid`=0, `rr_ptr`=0; the same check with `rstn` low → all outputs at reset values immediately.
